ttl_fifo_ctrl: RTL and testbench



---
 rtl/ttl_fifo_pkg.sv | 21 ++
 rtl/ttl_fifo_ctrl_if.sv | 12 +
 rtl/ttl_fifo_ctrl.sv | 149 ++++++++++++++
 tb/tb_ttl_fifo_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttl_fifo_pkg.sv
// Shared types, default sizing and pointer helper for the TTLx8 FIFO playout stage.
package ttl_fifo_pkg;

  localparam int DEF_DEPTH      = 1024;
  localparam int DEF_THRESHOLD  = 1000;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_HOLD_WIDTH = 16;

  // Playout sequencer: waiting for a word, or holding one on ttl_out.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } ttl_state_t;

  // Next storage index with wrap at depth-1; depth need not be a power of two.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/ttl_fifo_ctrl_if.sv
// Valid/ready word stream feeding the TTL FIFO. The producer drives valid and data,
// the FIFO answers with ready (space available).
interface ttl_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/ttl_fifo_ctrl.sv
// Pointer/occupancy control for an external FIFO array (sync write, comb read)
// plus a playout sequencer that holds each popped word on ttl_out for hold_len+1 cycles.
module ttl_fifo_ctrl
  import ttl_fifo_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int THRESHOLD  = DEF_THRESHOLD,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int HOLD_WIDTH = DEF_HOLD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  ttl_fifo_ctrl_if.slave        s_if,
  input  logic                  run,
  input  logic [HOLD_WIDTH-1:0] hold_len,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr_in,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] ttl_out,
  output logic                  ttl_strobe,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underrun
);

  localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_AF   = (ADDR_WIDTH + 1)'(THRESHOLD);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [HOLD_WIDTH-1:0] HOLD_ONE   = HOLD_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [HOLD_WIDTH-1:0] hold_cnt;
  ttl_state_t            state;
  ttl_state_t            state_nxt;
  logic                  push;
  logic                  pop;
  logic                  underrun_set;

  // Flags are pure decodes of the registered occupancy; ready uses the registered full,
  // so a pop in the same cycle never lets a push into a full FIFO.
  assign full          = (count == COUNT_FULL);
  assign empty         = (count == '0);
  assign almost_full   = (count >= COUNT_AF);
  assign s_if.s_ready  = !full;

  assign push          = s_if.s_valid && !full;
  assign mem_wr_en     = push;
  assign mem_addr_in   = wr_ptr;
  assign mem_din       = s_if.s_data;
  assign mem_addr_out  = rd_ptr;

  // Sequencer decode: decide whether to pop this cycle and where to go next.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_nxt    = state;
    pop          = 1'b0;
    underrun_set = 1'b0;
    case (state)
      IDLE: begin
        if (run && !empty) begin
          pop       = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          if (run && !empty) begin
            pop = 1'b1;
          end else begin
            underrun_set = run;
            state_nxt    = IDLE;
          end
        end
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values, matching hardware.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Output register and hold counter: load on pop, count down while holding.
  always_ff @(posedge clk) begin
    if (rst) begin
      ttl_out    <= '0;
      ttl_strobe <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      ttl_strobe <= pop;
      if (pop) begin
        ttl_out  <= mem_dout;
        hold_cnt <= hold_len;
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_ONE;
      end
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk) begin
    // NOTE: only the pointers and count are reset; the external array keeps stale contents, which is harmless since count marks none of it valid.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ADDR_WIDTH'(ptr_next(32'(wr_ptr), 32'(DEPTH)));
      end
      if (pop) begin
        rd_ptr <= ADDR_WIDTH'(ptr_next(32'(rd_ptr), 32'(DEPTH)));
      end
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (s_if.s_valid && full) begin
        overflow <= 1'b1;
      end
      if (underrun_set) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ttl_fifo_ctrl.sv
// Self-checking bench for ttl_fifo_ctrl: two instances (DEPTH 1024 and DEPTH 5),
// each with its own storage array and a queue-based reference model.
module tb_ttl_fifo_ctrl;
  import ttl_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s_valid_i [2];
  logic [7:0]  s_data_i  [2];
  logic        run_i     [2];
  logic [15:0] hold_i    [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int DEPTH_G = (g == 0) ? 1024 : 5;
    localparam int THR_G   = (g == 0) ? 1000 : 4;
    localparam int AW      = (g == 0) ? 10 : 3;

    ttl_fifo_ctrl_if #(.DATA_WIDTH(8)) bus ();

    logic          mem_wr_en;
    logic [AW-1:0] mem_addr_in;
    logic [7:0]    mem_din;
    logic [AW-1:0] mem_addr_out;
    logic [7:0]    mem_dout;
    logic [7:0]    ttl_out;
    logic          ttl_strobe;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          overflow;
    logic          underrun;
    logic          s_ready;

    assign bus.s_valid = s_valid_i[g];
    assign bus.s_data  = s_data_i[g];
    assign s_ready     = bus.s_ready;

    ttl_fifo_ctrl #(
      .DEPTH(DEPTH_G), .THRESHOLD(THR_G), .DATA_WIDTH(8), .ADDR_WIDTH(AW), .HOLD_WIDTH(16)
    ) u_dut (
      .clk(clk), .rst(rst), .s_if(bus), .run(run_i[g]), .hold_len(hold_i[g]),
      .mem_wr_en(mem_wr_en), .mem_addr_in(mem_addr_in), .mem_din(mem_din),
      .mem_addr_out(mem_addr_out), .mem_dout(mem_dout),
      .ttl_out(ttl_out), .ttl_strobe(ttl_strobe), .count(count),
      .full(full), .empty(empty), .almost_full(almost_full),
      .overflow(overflow), .underrun(underrun)
    );

    // Storage array: synchronous write, combinational read.
    logic [7:0] mem [2**AW];
    always @(posedge clk) if (mem_wr_en) mem[mem_addr_in] <= mem_din;
    assign mem_dout = mem[mem_addr_out];

    // Reference model: a queue of words plus "cycles left on the current word".
    logic [7:0]  q [$];
    int unsigned n_push = 0;
    int unsigned n_pop = 0;
    bit          active = 1'b0;
    int          remaining = 0;
    logic [7:0]  m_out = 8'h00;
    bit          m_strobe = 1'b0;
    bit          m_ovf = 1'b0;
    bit          m_und = 1'b0;
    bit          live = 1'b0;

    initial forever begin
      bit full_now;
      @(posedge clk);
      if (rst) begin
        q.delete();
        n_push = 0; n_pop = 0; active = 1'b0; remaining = 0;
        m_out = 8'h00; m_strobe = 1'b0; m_ovf = 1'b0; m_und = 1'b0;
        live = 1'b1;
      end else begin
        full_now = (q.size() == DEPTH_G);
        if (s_valid_i[g] && full_now) m_ovf = 1'b1;
        m_strobe = 1'b0;
        if (active && remaining > 0) begin
          remaining--;
        end else if (run_i[g] && q.size() > 0) begin
          m_out = q.pop_front();
          m_strobe = 1'b1;
          n_pop++;
          remaining = int'(hold_i[g]);
          active = 1'b1;
        end else begin
          if (active && run_i[g]) m_und = 1'b1;
          active = 1'b0;
        end
        if (s_valid_i[g] && !full_now) begin
          q.push_back(s_data_i[g]);
          n_push++;
        end
      end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
      if (live) begin
        string p;
        p = $sformatf("i%0d.", g);
        check({p, "count"},        32'(count),        32'(q.size()));
        check({p, "empty"},        32'(empty),        32'(q.size() == 0));
        check({p, "full"},         32'(full),         32'(q.size() == DEPTH_G));
        check({p, "almost_full"},  32'(almost_full),  32'(q.size() >= THR_G));
        check({p, "s_ready"},      32'(s_ready),      32'(q.size() != DEPTH_G));
        check({p, "mem_wr_en"},    32'(mem_wr_en),    32'(s_valid_i[g] && q.size() != DEPTH_G));
        check({p, "mem_din"},      32'(mem_din),      32'(s_data_i[g]));
        check({p, "mem_addr_in"},  32'(mem_addr_in),  n_push % DEPTH_G);
        check({p, "mem_addr_out"}, 32'(mem_addr_out), n_pop % DEPTH_G);
        check({p, "ttl_out"},      32'(ttl_out),      32'(m_out));
        check({p, "ttl_strobe"},   32'(ttl_strobe),   32'(m_strobe));
        check({p, "overflow"},     32'(overflow),     32'(m_ovf));
        check({p, "underrun"},     32'(underrun),     32'(m_und));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_valid_i[i] = 1'b0; s_data_i[i] = 8'h00; run_i[i] = 1'b0; hold_i[i] = 16'd0;
    end
    repeat (2) step();
    rst = 1'b0;
  endtask

  logic [7:0] ttl_s  [8];
  logic       strb_s [8];
  logic [7:0] seen [$];
  logic [7:0] first_word;
  int         n_strobes;

  initial begin
    // Reset and idle.
    do_reset();
    repeat (2) step();
    @(negedge clk);
    check("idle.empty",   32'(g_inst[0].empty),      32'd1);
    check("idle.count",   32'(g_inst[0].count),      32'd0);
    check("idle.ttl_out", 32'(g_inst[0].ttl_out),    32'h00);
    check("idle.s_ready", 32'(g_inst[0].s_ready),    32'd1);
    check("idle.strobe",  32'(g_inst[0].ttl_strobe), 32'd0);
    step();

    // Basic playout: two words, hold_len=2, then underrun.
    run_i[0] = 1'b1; hold_i[0] = 16'd2; s_valid_i[0] = 1'b1; s_data_i[0] = 8'hA5;
    step();
    s_data_i[0] = 8'h3C;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ttl_s[k]  = g_inst[0].ttl_out;
      strb_s[k] = g_inst[0].ttl_strobe;
      if (k == 6) check("play.underrun_early", 32'(g_inst[0].underrun), 32'd0);
      if (k == 7) check("play.underrun",       32'(g_inst[0].underrun), 32'd1);
      step();
      if (k == 0) s_valid_i[0] = 1'b0;
    end
    begin
      logic [7:0] exp_ttl [8];
      logic       exp_stb [8];
      exp_ttl = '{8'h00, 8'hA5, 8'hA5, 8'hA5, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
      exp_stb = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      n_strobes = 0;
      for (int k = 0; k < 8; k++) begin
        check($sformatf("play.ttl_out[%0d]", k), 32'(ttl_s[k]),  32'(exp_ttl[k]));
        check($sformatf("play.strobe[%0d]", k),  32'(strb_s[k]), 32'(exp_stb[k]));
        n_strobes += int'(strb_s[k]);
      end
      check("play.n_strobes", 32'(n_strobes), 32'd2);
    end
    run_i[0] = 1'b0;

    // Fill to DEPTH with run=0, then overflow.
    do_reset();
    first_word = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      s_valid_i[0] = 1'b1; s_data_i[0] = 8'($urandom);
      if (i == 0) first_word = s_data_i[0];
      @(negedge clk);
      if (i == 999)  check("fill.af_999",   32'(g_inst[0].almost_full), 32'd0);
      if (i == 1000) check("fill.af_1000",  32'(g_inst[0].almost_full), 32'd1);
      if (i == 1023) check("fill.full_1023", 32'(g_inst[0].full),       32'd0);
      step();
    end
    @(negedge clk);
    check("fill.full",     32'(g_inst[0].full),     32'd1);
    check("fill.count",    32'(g_inst[0].count),    32'd1024);
    check("fill.s_ready",  32'(g_inst[0].s_ready),  32'd0);
    check("fill.ovf_pre",  32'(g_inst[0].overflow), 32'd0);
    step();
    @(negedge clk);
    check("fill.overflow", 32'(g_inst[0].overflow), 32'd1);
    check("fill.count_ov", 32'(g_inst[0].count),    32'd1024);
    step();

    // Full with a pop in the same cycle: push refused, count drops.
    run_i[0] = 1'b1; hold_i[0] = 16'd0;
    step();
    run_i[0] = 1'b0; s_valid_i[0] = 1'b0;
    @(negedge clk);
    check("fullpop.count",   32'(g_inst[0].count),   32'd1023);
    check("fullpop.ttl_out", 32'(g_inst[0].ttl_out), 32'(first_word));
    step();

    // Simultaneous push and pop at count=3.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      s_valid_i[0] = 1'b1; s_data_i[0] = 8'(8'h10 + i);
      step();
    end
    s_valid_i[0] = 1'b0;
    @(negedge clk);
    check("simul.count_pre", 32'(g_inst[0].count), 32'd3);
    step();
    run_i[0] = 1'b1; hold_i[0] = 16'd5; s_valid_i[0] = 1'b1; s_data_i[0] = 8'h77;
    step();
    s_valid_i[0] = 1'b0; run_i[0] = 1'b0;
    @(negedge clk);
    check("simul.count",   32'(g_inst[0].count),      32'd3);
    check("simul.strobe",  32'(g_inst[0].ttl_strobe), 32'd1);
    check("simul.ttl_out", 32'(g_inst[0].ttl_out),    32'h10);
    repeat (3) step();

    // Wrap-around on the DEPTH=5 instance.
    do_reset();
    run_i[1] = 1'b1; hold_i[1] = 16'd0;
    seen.delete();
    for (int k = 0; k < 16; k++) begin
      s_valid_i[1] = (k < 12); s_data_i[1] = 8'(k + 1);
      @(negedge clk);
      if (g_inst[1].ttl_strobe) seen.push_back(g_inst[1].ttl_out);
      if (k == 5) check("wrap.addr_in_wrapped", 32'(g_inst[1].mem_addr_in), 32'd0);
      step();
    end
    check("wrap.n_words",  32'(seen.size()),        32'd12);
    for (int k = 0; k < 12 && k < seen.size(); k++)
      check($sformatf("wrap.word[%0d]", k), 32'(seen[k]), 32'(k + 1));
    check("wrap.overflow", 32'(g_inst[1].overflow), 32'd0);
    run_i[1] = 1'b0;

    // Reset in the middle of a long hold.
    do_reset();
    run_i[0] = 1'b1; hold_i[0] = 16'd100; s_valid_i[0] = 1'b1; s_data_i[0] = 8'h5A;
    step();
    s_valid_i[0] = 1'b0;
    step();
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rsthold.count",    32'(g_inst[0].count),      32'd0);
    check("rsthold.empty",    32'(g_inst[0].empty),      32'd1);
    check("rsthold.ttl_out",  32'(g_inst[0].ttl_out),    32'h00);
    check("rsthold.strobe",   32'(g_inst[0].ttl_strobe), 32'd0);
    check("rsthold.overflow", 32'(g_inst[0].overflow),   32'd0);
    check("rsthold.underrun", 32'(g_inst[0].underrun),   32'd0);
    step();
    hold_i[0] = 16'd0; s_valid_i[0] = 1'b1; s_data_i[0] = 8'h11;
    step();
    s_valid_i[0] = 1'b0;
    step();
    run_i[0] = 1'b0;
    @(negedge clk);
    check("rsthold.repop_strobe", 32'(g_inst[0].ttl_strobe), 32'd1);
    check("rsthold.repop_ttl",    32'(g_inst[0].ttl_out),    32'h11);
    check("rsthold.no_underrun",  32'(g_inst[0].underrun),   32'd0);
    step();

    // Randomized traffic on both instances, with occasional resets.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int pv;
      pv = 30 + 20 * ((c / 500) % 4);
      for (int i = 0; i < 2; i++) begin
        s_valid_i[i] = ($urandom_range(0, 99) < pv);
        s_data_i[i]  = 8'($urandom);
        run_i[i]     = ($urandom_range(0, 7) != 0) && ((c / 250) % 3 != 2);
        hold_i[i]    = 16'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid_i[i] = 1'b0; run_i[i] = 1'b0;
    end
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
